// File: rtl/lstm_pkg.sv
// lstm_pkg: definitions shared by the LSTM H/C address generators.
//   state_t    : generator state encoding (IDLE/INIT/RUN/DONE)
//   slot_addr  : memory address of cell k at timestep t; slot t=-1 is the zero slot
//   NUM_CELL_DEF, TIMESTEP_DEF, LAST : default geometry and its last address
package lstm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Timestep t occupies addresses num_cell*(t+1) .. num_cell*(t+1)+num_cell-1.
  function automatic int slot_addr(input int t, input int k, input int num_cell);
    return num_cell * (t + 1) + k;
  endfunction

  localparam int NUM_CELL_DEF = 8;
  localparam int TIMESTEP_DEF = 7;
  localparam int LAST         = slot_addr(TIMESTEP_DEF - 1, NUM_CELL_DEF - 1, NUM_CELL_DEF);

endpackage

// File: rtl/wr_chan.sv
// wr_chan: one write channel (C or H) of the H/C write address generator.
// Holds the channel address counter, registers the write strobe, address and
// data, and flags when the counter has moved past the last address.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : reload the counter with START_ADDR (run start)
//   init_wr     : issue a zero write to init_addr (zero-slot initialisation)
//   init_addr   : address of the zero write
//   acc         : accept data_in as the next result (qualified by the top)
//   data_in     : result word
//   wr/addr/data: registered memory write port
//   cnt         : current counter value (next result address)
//   fin         : counter has passed LAST_ADDR; further results are ignored
module wr_chan #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  init_wr,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic                  acc,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  fin
);

  // The counter stops at LAST_ADDR+1, which still fits in ADDR_WIDTH bits, so
  // "passed LAST" is a plain compare and the address can never wrap to 0.
  assign fin = (cnt > LAST_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr   <= 1'b0;
      addr <= '0;
      data <= '0;
      cnt  <= START_ADDR;
    end else begin
      // Strobe is single-cycle: it follows the request of the previous cycle.
      wr <= init_wr | acc;
      if (init_wr) begin
        addr <= init_addr;
        data <= '0;
      end else if (acc) begin
        addr <= cnt;
        data <= data_in;
      end
      if (clr) begin
        cnt <= START_ADDR;
      end else if (acc) begin
        cnt <= cnt + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/addr_gen_wr_hc.sv
// addr_gen_wr_hc: write-side address generator for the LSTM H and C state
// memories. Result k of timestep t is written to NUM_CELL*(t+1)+k; the t=-1
// slot (0..NUM_CELL-1) holds zeros for the paired read generator.
//   clk, rst               : clock, synchronous active-high reset
//   i_start                : start pulse, honoured in IDLE or DONE only
//   i_valid_c / i_data_c   : next c_t result
//   i_valid_h / i_data_h   : next h_t result
//   o_ready                : high in RUN; valids are sampled only then
//   o_wr_c/o_addr_c/o_data_c : C memory write port (1-cycle latency)
//   o_wr_h/o_addr_h/o_data_h : H memory write port (1-cycle latency)
//   o_done                 : high in DONE
//   o_err                  : sticky; an h result arrived ahead of its c result
// Build option: define ZERO_INIT_EN to write zeros to the t=-1 slot of both
// memories (INIT state) before each run; otherwise start goes straight to RUN.
// NUM_CELL*(TIMESTEP+1) must be below 2**ADDR_WIDTH.
module addr_gen_wr_hc
  import lstm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_valid_c,
  input  logic [DATA_WIDTH-1:0] i_data_c,
  input  logic                  i_valid_h,
  input  logic [DATA_WIDTH-1:0] i_data_h,
  output logic                  o_ready,
  output logic                  o_wr_c,
  output logic [ADDR_WIDTH-1:0] o_addr_c,
  output logic [DATA_WIDTH-1:0] o_data_c,
  output logic                  o_wr_h,
  output logic [ADDR_WIDTH-1:0] o_addr_h,
  output logic [DATA_WIDTH-1:0] o_data_h,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(slot_addr(0, 0, NUM_CELL));
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  =
    ADDR_WIDTH'(slot_addr(TIMESTEP - 1, NUM_CELL - 1, NUM_CELL));

  state_t                  state;
  logic                    start_ok;
  logic                    acc_c, acc_h;
  logic                    h_live, h_ok, h_err;
  logic                    fin_c, fin_h;
  logic [ADDR_WIDTH-1:0]   cnt_c, cnt_h;
  logic                    init_wr;
  logic [ADDR_WIDTH-1:0]   init_addr;

  assign start_ok = i_start && ((state == ST_IDLE) || (state == ST_DONE));

  // o_ready is a registered copy of "state == RUN", so it doubles as the run qualifier.
  assign acc_c  = o_ready && i_valid_c && !fin_c;
  assign h_live = o_ready && i_valid_h && !fin_h;
  // h_t needs c_t: an h write is allowed only while cnt_h stays below cnt_c
  // once this cycle's c write (if any) is counted.
  assign h_ok   = (cnt_h < cnt_c) || acc_c;
  assign acc_h  = h_live && h_ok;
  assign h_err  = h_live && !h_ok;

`ifdef ZERO_INIT_EN
  logic [ADDR_WIDTH-1:0] init_idx;
  // Address 0 is issued on the start edge itself so the eight zero writes
  // line up exactly with the eight INIT cycles; INIT's final cycle issues
  // nothing and hands over to RUN.
  assign init_wr   = start_ok || ((state == ST_INIT) && (init_idx < ADDR_WIDTH'(NUM_CELL)));
  assign init_addr = start_ok ? '0 : init_idx;
`else
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      o_ready <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
`ifdef ZERO_INIT_EN
      init_idx <= '0;
`endif
    end else begin
      if (start_ok) begin
        o_err <= 1'b0;
      end else if (h_err) begin
        o_err <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            o_done <= 1'b0;
`ifdef ZERO_INIT_EN
            state    <= ST_INIT;
            o_ready  <= 1'b0;
            init_idx <= ADDR_WIDTH'(1);
`else
            state    <= ST_RUN;
            o_ready  <= 1'b1;
`endif
          end
        end

        ST_INIT: begin
`ifdef ZERO_INIT_EN
          if (init_idx == ADDR_WIDTH'(NUM_CELL)) begin
            state   <= ST_RUN;
            o_ready <= 1'b1;
          end else begin
            init_idx <= init_idx + ADDR_WIDTH'(1);
          end
`else
          state   <= ST_RUN;
          o_ready <= 1'b1;
`endif
        end

        ST_RUN: begin
          // Counters are past LAST only after the final write has been
          // registered, so DONE lands the cycle after that write is visible.
          if (fin_c && fin_h) begin
            state   <= ST_DONE;
            o_ready <= 1'b0;
            o_done  <= 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          o_ready <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

  wr_chan #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .START_ADDR(FIRST_ADDR),
    .LAST_ADDR (LAST_ADDR)
  ) u_chan_c (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .init_wr  (init_wr),
    .init_addr(init_addr),
    .acc      (acc_c),
    .data_in  (i_data_c),
    .wr       (o_wr_c),
    .addr     (o_addr_c),
    .data     (o_data_c),
    .cnt      (cnt_c),
    .fin      (fin_c)
  );

  wr_chan #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .START_ADDR(FIRST_ADDR),
    .LAST_ADDR (LAST_ADDR)
  ) u_chan_h (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .init_wr  (init_wr),
    .init_addr(init_addr),
    .acc      (acc_h),
    .data_in  (i_data_h),
    .wr       (o_wr_h),
    .addr     (o_addr_h),
    .data     (o_data_h),
    .cnt      (cnt_h),
    .fin      (fin_h)
  );

endmodule

// File: tb/tb_addr_gen_wr_hc.sv
// tb_addr_gen_wr_hc: self-checking bench for addr_gen_wr_hc (NUM_CELL=8,
// TIMESTEP=7). A behavioural model counts results per channel and maps item
// n to slot (n/NUM_CELL, n%NUM_CELL); every cycle's outputs are compared with
// the model. Zero-slot initialisation is exercised when ZERO_INIT_EN is defined.
module tb_addr_gen_wr_hc;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int TS    = 7;
  localparam int NC    = 8;
  localparam int TOTAL = NC * TS;

  typedef struct packed {
    logic          rdy;
    logic          done;
    logic          err;
    logic          wr_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] data_c;
    logic          wr_h;
    logic [AW-1:0] addr_h;
    logic [DW-1:0] data_h;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_valid_c = 1'b0;
  logic [DW-1:0] i_data_c = '0;
  logic          i_valid_h = 1'b0;
  logic [DW-1:0] i_data_h = '0;
  logic          o_ready, o_wr_c, o_wr_h, o_done, o_err;
  logic [AW-1:0] o_addr_c, o_addr_h;
  logic [DW-1:0] o_data_c, o_data_h;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int mc, mh;
  bit m_ready, m_done, m_err, m_init;
  int zq[$];

  always #5 clk = ~clk;

  addr_gen_wr_hc #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMESTEP  (TS),
    .NUM_CELL  (NC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_valid_c(i_valid_c),
    .i_data_c (i_data_c),
    .i_valid_h(i_valid_h),
    .i_data_h (i_data_h),
    .o_ready  (o_ready),
    .o_wr_c   (o_wr_c),
    .o_addr_c (o_addr_c),
    .o_data_c (o_data_c),
    .o_wr_h   (o_wr_h),
    .o_addr_h (o_addr_h),
    .o_data_h (o_data_h),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  // Item n is cell n%NC of timestep n/NC.
  function automatic int addr_of(input int n);
    return NC * ((n / NC) + 1) + (n % NC);
  endfunction

  function automatic obs_t sample();
    obs_t v;
    v.rdy = o_ready; v.done = o_done; v.err = o_err;
    v.wr_c = o_wr_c; v.addr_c = o_addr_c; v.data_c = o_data_c;
    v.wr_h = o_wr_h; v.addr_h = o_addr_h; v.data_h = o_data_h;
    return v;
  endfunction

  // Address/data only matter while the strobe is high.
  function automatic obs_t mask(input obs_t v);
    obs_t m = v;
    if (!m.wr_c) begin m.addr_c = '0; m.data_c = '0; end
    if (!m.wr_h) begin m.addr_h = '0; m.data_h = '0; end
    return m;
  endfunction

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit rs, input bit st, input bit vc, input logic [DW-1:0] dc,
                     input bit vh, input logic [DW-1:0] dh, output obs_t e, output obs_t g);
    bit ct, ht, hlive, fin_now, init_end, st_ok;
    rst = rs; i_start = st; i_valid_c = vc; i_data_c = dc; i_valid_h = vh; i_data_h = dh;
    @(posedge clk);
    e = '0; ct = 0; ht = 0;
    if (rs) begin
      mc = 0; mh = 0; m_ready = 0; m_done = 0; m_err = 0; m_init = 0;
      zq.delete();
    end else begin
      st_ok    = st && !m_ready && !m_init;
      fin_now  = m_ready && (mc == TOTAL) && (mh == TOTAL);
      init_end = m_init && (zq.size() == 0);
      if (m_ready) begin
        ct    = vc && (mc < TOTAL);
        hlive = vh && (mh < TOTAL);
        ht    = hlive && (mh < mc + int'(ct));
        if (hlive && !ht) m_err = 1;
      end
      if (ct) begin e.wr_c = 1; e.addr_c = AW'(addr_of(mc)); e.data_c = dc; mc++; end
      if (ht) begin e.wr_h = 1; e.addr_h = AW'(addr_of(mh)); e.data_h = dh; mh++; end
      if (fin_now) begin m_ready = 0; m_done = 1; end
      if (init_end) begin m_init = 0; m_ready = 1; end
      if (st_ok) begin
        mc = 0; mh = 0; m_err = 0; m_done = 0;
`ifdef ZERO_INIT_EN
        for (int k = 0; k < NC; k++) zq.push_back(k);
        m_init = 1;
`else
        m_ready = 1;
`endif
      end
      if (zq.size() > 0) begin
        int a;
        a = zq.pop_front();
        e.wr_c = 1; e.addr_c = AW'(a); e.data_c = '0;
        e.wr_h = 1; e.addr_h = AW'(a); e.data_h = '0;
      end
    end
    e.rdy = m_ready; e.done = m_done; e.err = m_err;
    #1;
    g = sample();
  endtask

  task automatic test_reset();
    obs_t e, g;
    cyc(1, 0, 0, '0, 0, '0, e, g);
    vectors++;
    if (g !== '0) begin
      miscompares++;
      $display("FAIL reset got=%p exp=0", g);
    end
    cyc(0, 0, 1, 16'h1234, 1, 16'h5678, e, g);
    vectors++;
    if (mask(g) !== mask(e)) begin
      miscompares++;
      $display("FAIL idle_valid got=%p exp=%p", g, e);
    end
  endtask

  // Start the run and wait out zero-slot initialisation if it is built in.
  task automatic start_run(input string tag);
    obs_t e, g;
    int guard;
    cyc(0, 1, 0, '0, 0, '0, e, g);
    vectors++;
    if (mask(g) !== mask(e)) begin
      miscompares++;
      $display("FAIL %s_start got=%p exp=%p", tag, g, e);
    end
    guard = 0;
    while (!m_ready && guard < 20) begin
      cyc(0, 0, 0, '0, 0, '0, e, g);
      vectors++;
      if (mask(g) !== mask(e)) begin
        miscompares++;
        $display("FAIL %s_init got=%p exp=%p", tag, g, e);
      end
      guard++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    int last_wr = -100, done_at = -100;
    start_run("b2b");
    for (int i = 0; i < TOTAL + 4; i++) begin
      bit v = (i < TOTAL);
      cyc(0, 0, v, DW'($urandom), v, DW'($urandom), e, g);
      vectors++;
      if (mask(g) !== mask(e)) begin
        miscompares++;
        $display("FAIL b2b[%0d] got=%p exp=%p", i, g, e);
      end
      if (g.wr_c && g.wr_h && g.addr_c == AW'(63) && g.addr_h == AW'(63)) last_wr = i;
      if (g.done && done_at < 0) done_at = i;
    end
    vectors++;
    if (done_at - last_wr !== 1) begin
      miscompares++;
      $display("FAIL b2b_done_timing got=%0d exp=1 (done %0d, last write %0d)",
               done_at - last_wr, done_at, last_wr);
    end
  endtask

  task automatic test_h_lag();
    obs_t e, g;
    start_run("lag");
    for (int i = 0; i < TOTAL + 6; i++) begin
      bit vc = (i < TOTAL);
      bit vh = (i >= 3) && (i < TOTAL + 3);
      cyc(0, 0, vc, DW'($urandom), vh, DW'($urandom), e, g);
      vectors++;
      if (mask(g) !== mask(e)) begin
        miscompares++;
        $display("FAIL lag[%0d] got=%p exp=%p", i, g, e);
      end
    end
    vectors++;
    if (g.err !== 1'b0 || g.done !== 1'b1) begin
      miscompares++;
      $display("FAIL lag_end got err=%0b done=%0b exp err=0 done=1", g.err, g.done);
    end
  endtask

  task automatic test_h_first();
    obs_t e, g;
    cyc(0, 1, 0, '0, 0, '0, e, g);  // DONE from previous test: restart
    while (!m_ready) cyc(0, 0, 0, '0, 0, '0, e, g);
    cyc(0, 0, 0, '0, 1, 16'hBEEF, e, g);
    vectors++;
    if (g.wr_h !== 1'b0 || g.err !== 1'b1 || mask(g) !== mask(e)) begin
      miscompares++;
      $display("FAIL h_first got=%p exp wr_h=0 err=1", g);
    end
    cyc(0, 0, 1, 16'hCAFE, 0, '0, e, g);
    vectors++;
    if (g.wr_c !== 1'b1 || g.addr_c !== AW'(8) || g.data_c !== 16'hCAFE || mask(g) !== mask(e)) begin
      miscompares++;
      $display("FAIL h_first_c got=%p exp wr_c=1 addr_c=8 data_c=cafe", g);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    cyc(1, 0, 0, '0, 0, '0, e, g);
    start_run("rmid");
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, DW'($urandom), 0, '0, e, g);
      vectors++;
      if (mask(g) !== mask(e)) begin
        miscompares++;
        $display("FAIL rmid[%0d] got=%p exp=%p", i, g, e);
      end
    end
    cyc(1, 0, 1, 16'h7777, 1, 16'h8888, e, g);
    vectors++;
    if (g !== '0) begin
      miscompares++;
      $display("FAIL rmid_reset got=%p exp=0", g);
    end
    cyc(0, 0, 1, 16'h9999, 0, '0, e, g);
    vectors++;
    if (g !== '0) begin
      miscompares++;
      $display("FAIL rmid_idle got=%p exp=0", g);
    end
    start_run("rmid2");
    cyc(0, 0, 1, 16'h4321, 0, '0, e, g);
    vectors++;
    if (g.wr_c !== 1'b1 || g.addr_c !== AW'(8) || mask(g) !== mask(e)) begin
      miscompares++;
      $display("FAIL rmid_restart got=%p exp wr_c=1 addr_c=8", g);
    end
  endtask

  task automatic test_overflow();
    obs_t e, g;
    int writes = 0, max_addr = 0, min_addr = 4096;
    cyc(1, 0, 0, '0, 0, '0, e, g);
    start_run("ovf");
    for (int i = 0; i < 64; i++) begin
      cyc(0, 0, (i < 60), DW'($urandom), 0, '0, e, g);
      vectors++;
      if (mask(g) !== mask(e)) begin
        miscompares++;
        $display("FAIL ovf[%0d] got=%p exp=%p", i, g, e);
      end
      if (g.wr_c) begin
        writes++;
        if (int'(g.addr_c) > max_addr) max_addr = int'(g.addr_c);
        if (int'(g.addr_c) < min_addr) min_addr = int'(g.addr_c);
      end
    end
    vectors++;
    if (writes !== TOTAL || max_addr !== 63 || min_addr !== 8) begin
      miscompares++;
      $display("FAIL ovf_count got writes=%0d max=%0d min=%0d exp 56/63/8", writes, max_addr, min_addr);
    end
  endtask

  task automatic test_random();
    obs_t e, g;
    cyc(1, 0, 0, '0, 0, '0, e, g);
    start_run("rnd");
    for (int i = 0; i < 400; i++) begin
      bit st = ($urandom_range(0, 39) == 0);
      bit vc = ($urandom_range(0, 9) < 6);
      bit vh = ($urandom_range(0, 9) < 5);
      cyc(0, st, vc, DW'($urandom), vh, DW'($urandom), e, g);
      vectors++;
      if (mask(g) !== mask(e)) begin
        miscompares++;
        $display("FAIL rnd[%0d] got=%p exp=%p", i, g, e);
      end
    end
  endtask

`ifdef ZERO_INIT_EN
  task automatic test_zero_init();
    obs_t e, g;
    cyc(1, 0, 0, '0, 0, '0, e, g);
    cyc(0, 1, 0, '0, 0, '0, e, g);
    for (int i = 0; i < NC; i++) begin
      vectors++;
      if (g.rdy !== 1'b0 || g.wr_c !== 1'b1 || g.wr_h !== 1'b1 || g.addr_c !== AW'(i) ||
          g.addr_h !== AW'(i) || g.data_c !== '0 || g.data_h !== '0) begin
        miscompares++;
        $display("FAIL zinit[%0d] got=%p exp zero write to %0d", i, g, i);
      end
      cyc(0, 0, 1, 16'h1111, 1, 16'h2222, e, g);
    end
    vectors++;
    if (g.rdy !== 1'b1 || g.wr_c !== 1'b0 || mask(g) !== mask(e)) begin
      miscompares++;
      $display("FAIL zinit_ready got=%p exp=%p", g, e);
    end
    cyc(0, 0, 1, 16'h3333, 0, '0, e, g);
    vectors++;
    if (g.wr_c !== 1'b1 || g.addr_c !== AW'(8) || mask(g) !== mask(e)) begin
      miscompares++;
      $display("FAIL zinit_first got=%p exp wr_c=1 addr_c=8", g);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_h_lag();
    test_h_first();
    test_reset_mid();
    test_overflow();
    test_random();
`ifdef ZERO_INIT_EN
    test_zero_init();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
